// File: rtl/wr_active_vertex.sv
// wr_active_vertex
// Write-back stage that closes the active-vertex loop. Results from the last
// pipeline stage are buffered in a small FIFO and streamed one per cycle onto
// the backend bitmap write bus. An outstanding-vertex counter tracks work in
// flight between the front-end issue point and the result return. A short FSM
// raises a one-cycle iteration-end pulse once the front end has ended the
// iteration and the pipeline, the FIFO and the output register are all idle.
//
// Optional feature macro: WR_AV_FILTER_EN
//   defined   : results with result_v_updated==0 are not buffered or forwarded
//               (they still retire from the outstanding counter)
//   undefined : every result is buffered and forwarded
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   front_active_v_id_valid      one vertex issued into the pipeline
//   front_iteration_end(_valid)  front-end end-of-iteration level + qualifier
//   result_v_id/_updated/_valid  returning vertex result
//   result_full                  backpressure, occupancy >= FIFO_AFULL
//   backend_active_v_id/_updated/_id_valid   bitmap write bus
//   backend_iteration_end(_valid)            iteration-complete pulse
//   err                          sticky protocol error
//
// FSM states
//   state   | meaning
//   S_RUN   | normal operation, waiting for front-end iteration end
//   S_DRAIN | end seen, waiting for counter, FIFO, output and input to go idle
//   S_END   | end pulse is on the outputs this cycle
//   S_WAIT  | pulse given, waiting for the front-end end level to drop

`ifndef V_ID_WIDTH
`define V_ID_WIDTH 16
`endif

module wr_active_vertex #(
   parameter int V_ID_WIDTH = `V_ID_WIDTH,
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AFULL = 12,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  front_active_v_id_valid,
   input  logic                  front_iteration_end,
   input  logic                  front_iteration_end_valid,
   input  logic [V_ID_WIDTH-1:0] result_v_id,
   input  logic                  result_v_updated,
   input  logic                  result_v_valid,
   output logic                  result_full,
   output logic [V_ID_WIDTH-1:0] backend_active_v_id,
   output logic                  backend_active_v_updated,
   output logic                  backend_active_v_id_valid,
   output logic                  backend_iteration_end,
   output logic                  backend_iteration_end_valid,
   output logic                  err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] AFULL_C = (AW+1)'(FIFO_AFULL);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_END, S_WAIT} state_t;

   state_t                 state;
   logic [V_ID_WIDTH:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            count;
   logic [CNT_WIDTH-1:0]   outst;

   logic                   keep;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   wr_req;
   logic                   wr_en;
   logic                   rd_en;
   logic                   inc;
   logic                   dec;
   logic                   drained;
   logic [V_ID_WIDTH:0]    rd_data;

`ifdef WR_AV_FILTER_EN
   assign keep = result_v_updated;
`else
   assign keep = 1'b1;
`endif

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == DEPTH_C);
   assign result_full = (count >= AFULL_C);

   // A full check ignores a same-cycle pop: the write is still dropped.
   assign wr_req  = result_v_valid && keep;
   assign wr_en   = wr_req && !fifo_full;
   assign rd_en   = !fifo_empty;
   assign rd_data = mem[rd_ptr];

   assign inc = front_active_v_id_valid && !result_v_valid;
   assign dec = result_v_valid && !front_active_v_id_valid;

   // The output register must itself be low so the last drained write has
   // left the bus before the end pulse.
   assign drained = (outst == '0) && fifo_empty && !backend_active_v_id_valid
                    && !result_v_valid;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {result_v_id, result_v_updated};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         count                       <= '0;
         outst                       <= '0;
         err                         <= 1'b0;
         state                       <= S_RUN;
         backend_active_v_id         <= '0;
         backend_active_v_updated    <= 1'b0;
         backend_active_v_id_valid   <= 1'b0;
         backend_iteration_end       <= 1'b0;
         backend_iteration_end_valid <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;

         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         backend_active_v_id_valid <= rd_en;
         backend_active_v_id       <= rd_en ? rd_data[V_ID_WIDTH:1] : '0;
         backend_active_v_updated  <= rd_en & rd_data[0];

         if (inc) begin
            if (outst == '1) err   <= 1'b1;
            else             outst <= outst + 1'b1;
         end else if (dec) begin
            if (outst == '0) err   <= 1'b1;
            else             outst <= outst - 1'b1;
         end

         if (wr_req && fifo_full) err <= 1'b1;

         backend_iteration_end       <= 1'b0;
         backend_iteration_end_valid <= 1'b0;
         case (state)
            S_RUN: begin
               if (front_iteration_end && front_iteration_end_valid)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (drained) begin
                  state                       <= S_END;
                  backend_iteration_end       <= 1'b1;
                  backend_iteration_end_valid <= 1'b1;
               end
            end
            S_END: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (!front_iteration_end) state <= S_RUN;
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_wr_active_vertex.sv
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 16
`endif

module tb_wr_active_vertex;

   localparam int VW    = `V_ID_WIDTH;
   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          front_active_v_id_valid;
   logic          front_iteration_end;
   logic          front_iteration_end_valid;
   logic [VW-1:0] result_v_id;
   logic          result_v_updated;
   logic          result_v_valid;
   logic          result_full;
   logic [VW-1:0] backend_active_v_id;
   logic          backend_active_v_updated;
   logic          backend_active_v_id_valid;
   logic          backend_iteration_end;
   logic          backend_iteration_end_valid;
   logic          err;

   wr_active_vertex #(
      .V_ID_WIDTH(VW), .FIFO_DEPTH(DEPTH), .FIFO_AFULL(AFULL), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .front_active_v_id_valid(front_active_v_id_valid),
      .front_iteration_end(front_iteration_end),
      .front_iteration_end_valid(front_iteration_end_valid),
      .result_v_id(result_v_id),
      .result_v_updated(result_v_updated),
      .result_v_valid(result_v_valid),
      .result_full(result_full),
      .backend_active_v_id(backend_active_v_id),
      .backend_active_v_updated(backend_active_v_updated),
      .backend_active_v_id_valid(backend_active_v_id_valid),
      .backend_iteration_end(backend_iteration_end),
      .backend_iteration_end_valid(backend_iteration_end_valid),
      .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [VW-1:0] id; logic upd; } ent_t;
   ent_t          q[$];
   int            m_outst;
   logic          m_vld, m_upd, m_err, m_full, m_pulse;
   logic [VW-1:0] m_id;
   bit            m_armed, m_hold;

   always @(posedge clk) begin
      bit   idle_now, keep, full_pre;
      ent_t e;
      cyc++;
      if (rst) begin
         q.delete();
         m_outst = 0; m_vld = 0; m_id = '0; m_upd = 0; m_err = 0;
         m_full = 0; m_pulse = 0; m_armed = 0; m_hold = 0;
      end else begin
         idle_now = (m_outst == 0) && (q.size() == 0) && !m_vld && !result_v_valid;
         if (m_pulse) begin
            m_pulse = 0; m_hold = 1;
         end else if (m_hold) begin
            if (!front_iteration_end) m_hold = 0;
         end else if (m_armed) begin
            if (idle_now) begin m_armed = 0; m_pulse = 1; end
         end else if (front_iteration_end && front_iteration_end_valid) begin
            m_armed = 1;
         end

`ifdef WR_AV_FILTER_EN
         keep = result_v_updated;
`else
         keep = 1'b1;
`endif
         full_pre = (q.size() >= DEPTH);
         if (q.size() > 0) begin
            e = q.pop_front();
            m_vld = 1; m_id = e.id; m_upd = e.upd;
         end else begin
            m_vld = 0; m_id = '0; m_upd = 0;
         end
         if (result_v_valid && keep) begin
            if (full_pre) m_err = 1;
            else begin e.id = result_v_id; e.upd = result_v_updated; q.push_back(e); end
         end

         if (front_active_v_id_valid && !result_v_valid) begin
            if (m_outst == (1 << CW) - 1) m_err = 1; else m_outst++;
         end else if (result_v_valid && !front_active_v_id_valid) begin
            if (m_outst == 0) m_err = 1; else m_outst--;
         end
         m_full = (q.size() >= AFULL);
      end
   end

   // ---------------- compare + event log ----------------
   int            out_cyc[$];
   logic [VW-1:0] out_id[$];
   logic          out_upd[$];
   int            end_cyc[$];
   bit            full_seen = 0;

   always @(negedge clk) begin
      chk("out_valid", 64'(backend_active_v_id_valid), 64'(m_vld));
      chk("out_id",    64'(backend_active_v_id),       64'(m_id));
      chk("out_upd",   64'(backend_active_v_updated),  64'(m_upd));
      chk("end",       64'(backend_iteration_end),     64'(m_pulse));
      chk("end_valid", 64'(backend_iteration_end_valid), 64'(m_pulse));
      chk("err",       64'(err),                       64'(m_err));
      chk("full",      64'(result_full),               64'(m_full));
      if (backend_active_v_id_valid) begin
         out_cyc.push_back(cyc);
         out_id.push_back(backend_active_v_id);
         out_upd.push_back(backend_active_v_updated);
      end
      if (backend_iteration_end) end_cyc.push_back(cyc);
      if (result_full) full_seen = 1;
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clr_logs();
      out_cyc.delete(); out_id.delete(); out_upd.delete(); end_cyc.delete();
   endtask

   task automatic issue(int n);
      front_active_v_id_valid = 1; tick(n); front_active_v_id_valid = 0;
   endtask

   task automatic result(logic [VW-1:0] id, logic upd);
      result_v_id = id; result_v_updated = upd; result_v_valid = 1;
      tick();
      result_v_valid = 0; result_v_id = '0; result_v_updated = 0;
   endtask

   task automatic set_end(logic v);
      front_iteration_end = v; front_iteration_end_valid = v;
   endtask

   initial begin
      int rc, sc, sc2;
      rst = 1; front_active_v_id_valid = 0; set_end(0);
      result_v_id = '0; result_v_updated = 0; result_v_valid = 0;
      tick(3);
      @(negedge clk);
      chk("reset_out_valid", 64'(backend_active_v_id_valid), 0);
      chk("reset_err", 64'(err), 0);
      #1 rst = 0;
      tick(2);

      // single vertex
      clr_logs();
      issue(1); tick(2);
      rc = cyc; result(VW'(8'h25), 1); tick(5);
      chk("single_count", 64'(out_cyc.size()), 1);
      if (out_cyc.size() == 1) begin
         chk("single_lat", 64'(out_cyc[0] - rc), 2);
         chk("single_id",  64'(out_id[0]), 64'h25);
         chk("single_upd", 64'(out_upd[0]), 1);
      end
      chk("single_err", 64'(err), 0);

      // back-to-back burst
      clr_logs(); full_seen = 0;
      issue(20);
      rc = cyc;
      for (int i = 0; i < 20; i++) result(VW'(8'h40 + i), 1);
      tick(5);
      chk("burst_count", 64'(out_cyc.size()), 20);
      chk("burst_full_seen", 64'(full_seen), 0);
      for (int i = 0; i < 20 && i < out_cyc.size(); i++) begin
         chk("burst_id",  64'(out_id[i]), 64'(8'h40 + i));
         chk("burst_cyc", 64'(out_cyc[i]), 64'(rc + 2 + i));
      end

      // end gating
      clr_logs();
      issue(4);
      result(VW'(8'h60), 1); result(VW'(8'h61), 1);
      set_end(1); tick(10);
      chk("gate_no_early_end", 64'(end_cyc.size()), 0);
      result(VW'(8'h62), 1); result(VW'(8'h63), 1);
      tick(10);
      chk("gate_one_end", 64'(end_cyc.size()), 1);
      chk("gate_outputs", 64'(out_cyc.size()), 4);
      if (end_cyc.size() >= 1 && out_cyc.size() >= 1)
         chk("gate_gap_ge2", 64'((end_cyc[0] - out_cyc[out_cyc.size()-1]) >= 2), 1);
      tick(10);
      chk("gate_no_second", 64'(end_cyc.size()), 1);
      set_end(0); tick(3);

      // empty iteration, twice
      clr_logs();
      set_end(1); sc = cyc; tick(5); set_end(0); tick(3);
      set_end(1); sc2 = cyc; tick(5); set_end(0); tick(3);
      chk("empty_pulses", 64'(end_cyc.size()), 2);
      if (end_cyc.size() == 2) begin
         chk("empty_lat1", 64'(end_cyc[0] - sc), 2);
         chk("empty_lat2", 64'(end_cyc[1] - sc2), 2);
      end

      // filter
      clr_logs();
      issue(3);
      result(VW'(1), 1); result(VW'(2), 0); result(VW'(3), 1);
      set_end(1); tick(8); set_end(0); tick(3);
      chk("filter_end", 64'(end_cyc.size()), 1);
`ifdef WR_AV_FILTER_EN
      chk("filter_count", 64'(out_cyc.size()), 2);
      if (out_cyc.size() == 2) begin
         chk("filter_id0", 64'(out_id[0]), 1);
         chk("filter_id1", 64'(out_id[1]), 3);
      end
`else
      chk("filter_count", 64'(out_cyc.size()), 3);
      if (out_cyc.size() == 3) begin
         chk("filter_id0", 64'(out_id[0]), 1);
         chk("filter_id1", 64'(out_id[1]), 2);
         chk("filter_upd1", 64'(out_upd[1]), 0);
         chk("filter_id2", 64'(out_id[2]), 3);
      end
`endif

      // underflow: err set, counter held at 0 so an end still completes
      clr_logs();
      result(VW'(7), 1); tick();
      @(negedge clk);
      chk("uflow_err", 64'(err), 1);
      #1 set_end(1); tick(8); set_end(0); tick(3);
      chk("uflow_end", 64'(end_cyc.size()), 1);

      // reset mid-drain
      clr_logs();
      issue(2); set_end(1);
      result(VW'(9), 1); tick(5);
      chk("drain_no_end", 64'(end_cyc.size()), 0);
      rst = 1; tick();
      @(negedge clk);
      chk("rst_out_valid", 64'(backend_active_v_id_valid), 0);
      chk("rst_out_id", 64'(backend_active_v_id), 0);
      chk("rst_end", 64'(backend_iteration_end), 0);
      chk("rst_err", 64'(err), 0);
      #1 set_end(0); tick(2);
      rst = 0; tick(10);
      chk("rst_no_end", 64'(end_cyc.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
